// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder/subtractor.
// The master drives operands and start; the slave returns status and the registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice reused LSB first, one bit per clock.
// Results appear only on completion and hold until the next completion or reset.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic bit_a_s;
    logic bit_b_s;
    logic slice_sum_s;
    logic slice_carry_s;

    // In subtract mode B is inverted per bit; the seed carry was already inverted at accept.
    assign bit_a_s       = a_q[cnt_q];
    assign bit_b_s       = b_q[cnt_q] ^ sub_q;
    assign slice_sum_s   = fa_sum(bit_a_s, bit_b_s, carry_q);
    assign slice_carry_s = fa_carry(bit_a_s, bit_b_s, carry_q);

    // Next-state, datapath and status decode.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.sub;
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d[cnt_q] = slice_sum_s;
                carry_d      = slice_carry_s;
                if (cnt_q == LAST_BIT) begin
                    sum_d   = acc_d;
                    cout_d  = slice_carry_s;
                    // carry_q is the carry into the MSB slice at this edge
                    ovf_d   = carry_q ^ slice_carry_s;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder at WIDTH=8 and WIDTH=1,
// compared against an integer-arithmetic reference model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] last_sum8;
    logic       last_cout8;
    logic       last_ovf8;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Plain arithmetic: add a+b+cin, or subtract a-b-cin (cout = no borrow);
    // ovf = the signed result does not fit in w bits.
    function automatic void ref_add(input int w, input bit sub, input longint a, input longint b,
                                    input bit cin, output longint s, output bit co, output bit ov);
        longint m  = longint'(1) << w;
        longint c  = cin;
        longint sa = (a >= m / 2) ? a - m : a;
        longint sb = (b >= m / 2) ? b - m : b;
        longint t;
        longint st;
        if (!sub) begin
            t  = a + b + c;
            co = (t >= m);
            s  = t % m;
            st = sa + sb + c;
        end else begin
            t  = a - b - c;
            co = (t >= 0);
            s  = (t + m) % m;
            st = sa - sb - c;
        end
        ov = (st < -(m / 2)) || (st > (m / 2) - 1);
    endfunction

    task automatic scramble8();
        if8.a   = 8'($urandom);
        if8.b   = 8'($urandom);
        if8.sub = 1'($urandom);
        if8.cin = 1'($urandom);
    endtask

    task automatic run8(input bit sub, input logic [7:0] a, input logic [7:0] b, input bit cin,
                        input bit mid_start);
        longint es;
        bit     ec;
        bit     eo;
        int     lat;
        int     busy_cyc;
        bit     seen;
        ref_add(8, sub, longint'(a), longint'(b), cin, es, ec, eo);
        if8.start = 1'b1;
        if8.sub   = sub;
        if8.a     = a;
        if8.b     = b;
        if8.cin   = cin;
        @(posedge clk); #1;
        if8.start = 1'b0;
        scramble8();
        check_eq("busy_after_accept", 64'(if8.busy), 64'd1);
        check_eq("hold_after_accept", {if8.ovf, if8.cout, if8.sum}, {last_ovf8, last_cout8, last_sum8});
        busy_cyc = if8.busy ? 1 : 0;
        lat      = 0;
        seen     = 1'b0;
        while (!seen && lat < 40) begin
            if (mid_start && lat == 3) begin
                if8.start = 1'b1;
                scramble8();
            end else begin
                if8.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (if8.done) begin
                seen = 1'b1;
            end else begin
                if (if8.busy) busy_cyc++;
                check_eq("hold_in_run", {if8.ovf, if8.cout, if8.sum}, {last_ovf8, last_cout8, last_sum8});
            end
        end
        if8.start = 1'b0;
        check_eq("done_seen", 64'(seen), 64'd1);
        check_eq("latency8", 64'(lat), 64'd8);
        check_eq("busy_cycles8", 64'(busy_cyc), 64'd8);
        check_eq("busy_in_done", 64'(if8.busy), 64'd0);
        check_eq("sum8", 64'(if8.sum), 64'(es));
        check_eq("cout8", 64'(if8.cout), 64'(ec));
        check_eq("ovf8", 64'(if8.ovf), 64'(eo));
        last_sum8  = 8'(es);
        last_cout8 = ec;
        last_ovf8  = eo;
    endtask

    task automatic idle8();
        @(posedge clk); #1;
        check_eq("idle_done", 64'(if8.done), 64'd0);
        check_eq("idle_busy", 64'(if8.busy), 64'd0);
        check_eq("idle_hold", {if8.ovf, if8.cout, if8.sum}, {last_ovf8, last_cout8, last_sum8});
    endtask

    task automatic run1(input bit sub, input bit a, input bit b, input bit cin,
                        input bit es, input bit ec, input bit eo);
        int lat;
        if1.start = 1'b1;
        if1.sub   = sub;
        if1.a     = a;
        if1.b     = b;
        if1.cin   = cin;
        @(posedge clk); #1;
        if1.start = 1'b0;
        if1.a     = 1'($urandom);
        if1.b     = 1'($urandom);
        check_eq("busy1", 64'(if1.busy), 64'd1);
        lat = 0;
        while (!if1.done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency1", 64'(lat), 64'd1);
        check_eq("sum1", 64'(if1.sum), 64'(es));
        check_eq("cout1", 64'(if1.cout), 64'(ec));
        check_eq("ovf1", 64'(if1.ovf), 64'(eo));
        @(posedge clk); #1;
        check_eq("done1_pulse", 64'(if1.done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        longint es;
        bit     ec;
        bit     eo;
        int     dones;
        logic [7:0] ra;
        logic [7:0] rb;

        rst = 1'b1;
        if8.start = 1'b0; if8.sub = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0;
        if1.start = 1'b0; if1.sub = 1'b0; if1.a = 1'b0;  if1.b = 1'b0;  if1.cin = 1'b0;
        last_sum8 = 8'h00; last_cout8 = 1'b0; last_ovf8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_busy", 64'(if8.busy), 64'd0);
        check_eq("rst_done", 64'(if8.done), 64'd0);
        check_eq("rst_res8", {if8.ovf, if8.cout, if8.sum}, 64'd0);
        check_eq("rst_res1", {if1.ovf, if1.cout, if1.sum, if1.busy, if1.done}, 64'd0);

        run8(1'b0, 8'h55, 8'hAA, 1'b1, 1'b0);
        check_eq("dir_55_AA", {if8.ovf, if8.cout, if8.sum}, {1'b0, 1'b1, 8'h00});
        idle8();
        run8(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
        check_eq("dir_7F_01", {if8.ovf, if8.cout, if8.sum}, {1'b1, 1'b0, 8'h80});
        idle8();
        run8(1'b1, 8'h05, 8'h07, 1'b0, 1'b0);
        check_eq("dir_05_m_07", {if8.ovf, if8.cout, if8.sum}, {1'b0, 1'b0, 8'hFE});
        idle8();
        run8(1'b0, 8'h12, 8'h34, 1'b0, 1'b1);
        check_eq("ignored_start", 64'(if8.sum), 64'h46);
        idle8();
        idle8();

        // Reset in the fourth RUN cycle aborts with no done pulse.
        if8.start = 1'b1; if8.sub = 1'b0; if8.a = 8'hC3; if8.b = 8'h5A; if8.cin = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_busy", 64'(if8.busy), 64'd0);
        check_eq("abort_done", 64'(if8.done), 64'd0);
        check_eq("abort_res", {if8.ovf, if8.cout, if8.sum}, 64'd0);
        last_sum8 = 8'h00; last_cout8 = 1'b0; last_ovf8 = 1'b0;
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if8.done) dones++;
        end
        check_eq("abort_no_done", 64'(dones), 64'd0);

        // Reset wins over a simultaneous start.
        rst = 1'b1; if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0; if8.start = 1'b0;
        check_eq("rst_prio_busy", 64'(if8.busy), 64'd0);
        idle8();

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 10 == 0) rb = ra;
            run8(1'($urandom), ra, rb, 1'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle8();
        end
        idle8();

        for (int i = 0; i < 8; i++) begin
            bit ta;
            bit tb;
            bit tc;
            ta = i[2];
            tb = i[1];
            tc = i[0];
            ref_add(1, 1'b0, longint'(ta), longint'(tb), tc, es, ec, eo);
            run1(1'b0, ta, tb, tc, ta ^ tb ^ tc, (ta & tb) | (ta & tc) | (tb & tc), eo);
        end
        for (int i = 0; i < 8; i++) begin
            bit ta;
            bit tb;
            bit tc;
            ta = 1'($urandom);
            tb = 1'($urandom);
            tc = 1'($urandom);
            ref_add(1, 1'b1, longint'(ta), longint'(tb), tc, es, ec, eo);
            run1(1'b1, ta, tb, tc, es[0], ec, eo);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range WIDTH >= 1.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled on rising clk.
REQ-005 SHALL have port sub  input  1  mode: 0 = add, 1 = subtract; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port cin  input  1  carry-in (add) or borrow-in (sub); sampled with start.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  single-cycle pulse marking a valid result.
REQ-011 SHALL have port sum  output  WIDTH  registered result.
REQ-012 SHALL have port cout  output  1  raw carry out of the MSB.
REQ-013 SHALL have port ovf  output  1  two's-complement overflow flag.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE or DONE, start=1 at an edge SHALL be accepted: latch a, b, sub and cin, clear the bit counter, go to RUN.
REQ-016 Add mode SHALL compute a + b + cin.
REQ-017 Subtract mode SHALL compute a + ~b + ~cin, which equals a - b - cin; cout=1 means no borrow.
REQ-018 RUN SHALL process one bit per clock, LSB first, using one full-adder slice and a carry flip-flop seeded from the latched carry-in.
REQ-019 The bit processed at RUN edge i (i = 0..WIDTH-1) SHALL be bit i.
REQ-020 On the edge that processes bit WIDTH-1, the block SHALL load sum, cout and ovf and move to DONE.
REQ-021 Latency SHALL be exactly WIDTH edges from accepting start to done=1 in the following cycle.
REQ-022 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only, for exactly one cycle.
REQ-023 With no new start, DONE SHALL return to IDLE on the next edge.
REQ-024 ovf SHALL equal (carry into MSB) XOR (carry out of MSB) of the effective addition.
REQ-025 sum, cout and ovf SHALL hold their values from the last completion until the next completion or reset; they SHALL never show partial results.
REQ-026 start while in RUN SHALL be ignored; latched operands and mode SHALL be unaffected.
REQ-027 start in DONE SHALL be accepted back-to-back: done=1 in that cycle and busy=1 from the next cycle.
REQ-028 Operand inputs SHALL be don't-care except on an accepting edge.
REQ-029 For WIDTH=1, the result SHALL equal the 1-bit full-adder truth table (sum = a^b^cin, cout = majority) in add mode.

Reset
REQ-030 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear the counter, carry and internal operand registers.
REQ-031 rst SHALL take priority over start at the same edge.
REQ-032 rst asserted in RUN SHALL abort the operation without a done pulse.

Verification
REQ-033 WIDTH=8, add: a=0x55, b=0xAA, cin=1 -> done 8 cycles after start; sum=0x00, cout=1, ovf=0; busy high for exactly 8 cycles.
REQ-034 WIDTH=8, add: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-035 WIDTH=8, sub: a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0, ovf=0.
REQ-036 WIDTH=8: start pulsed again 3 cycles into RUN with different operands -> ignored; first result unchanged; exactly one done pulse.
REQ-037 WIDTH=8: rst at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse follows.
REQ-038 WIDTH=1, add: all 8 {a,b,cin} combinations -> sum and cout match the full-adder truth table; done 1 cycle after each start.
